// File: rtl/vram_pkg.sv
// Shared constants and FSM state type for the video RAM arbiter.
package vram_pkg;
  localparam int VRAM_AW = 13;
  localparam int VRAM_DW = 8;
  localparam logic [VRAM_AW-1:0] ATTR_BASE = 13'h1800;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_RD   = 2'd1,
    CPU_HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video reads always own the issue slot, CPU accesses fill free slots.
// Optional VRAM_CONTENTION_EN also blocks CPU issue while vid_window is high (ULA contention).
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
) (
  input  logic          clk_pix,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  input  logic          vid_window,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_wait,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int VID_STAGES = 2;

  state_t state, state_nxt;
  logic   issue_cpu, slot_blocked, ack_nxt;
  logic   rd_ph;     // CPU_RD second cycle: RAM data for the CPU read is now on mem_rdata
  logic   hold_wr;   // CPU_HOLD entered from a write issue, ack on exit
  logic [VID_STAGES:1] vld_pipe;

`ifdef VRAM_CONTENTION_EN
  assign slot_blocked = vid_req | vid_window;
`else
  logic unused_window;
  assign unused_window = vid_window;
  assign slot_blocked  = vid_req;
`endif

  // cpu_ack masks the level request during the ack cycle, before the master drops it
  assign issue_cpu = (state == IDLE) & cpu_req & ~cpu_ack & ~slot_blocked;
  assign cpu_wait  = cpu_req & ~cpu_ack & ~issue_cpu;

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    case (state)
      IDLE:     if (issue_cpu) state_nxt = cpu_we ? CPU_HOLD : CPU_RD;
      CPU_RD:   if (rd_ph) begin
                  state_nxt = CPU_HOLD;
                  ack_nxt   = 1'b1;
                end
      CPU_HOLD: begin
                  state_nxt = IDLE;
                  ack_nxt   = hold_wr;
                end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state     <= IDLE;
      rd_ph     <= 1'b0;
      hold_wr   <= 1'b0;
      vld_pipe  <= '0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      rd_ph     <= (state == CPU_RD) & ~rd_ph;
      cpu_ack   <= ack_nxt;
      vld_pipe  <= {vld_pipe[VID_STAGES-1:1], vid_req};
      vid_valid <= vld_pipe[VID_STAGES];
      if (vld_pipe[VID_STAGES]) vid_data <= mem_rdata;
      if (state == CPU_RD && rd_ph) cpu_rdata <= mem_rdata;
      mem_we <= issue_cpu & cpu_we;
      if (issue_cpu) hold_wr <= cpu_we;
      if (vid_req) begin
        mem_addr <= vid_addr;
      end else if (issue_cpu) begin
        mem_addr <= cpu_addr;
        if (cpu_we) mem_wdata <= cpu_wdata;
      end
    end
  end
endmodule
